input_mems_pp: RTL and testbench

Ping-pong (double-buffered) input memory for the matrix-multiply datapath. It accepts matrix A (M×K) and matrix B (K×N) over AXI-Stream into one of two buffer sets while the compute engine reads the other set, so the next load overlaps the current compute. Each set records its own K and which A bank it uses, so a stream may reuse the previously loaded A and send only a new B. It sits between the AXIS input and the MAC array/output controller.

---
 rtl/input_mems_pkg.sv | 21 ++
 rtl/pp_bank.sv | 36 +++
 rtl/input_mems_pp.sv | 214 +++++++++++++++++++++
 tb/tb_input_mems_pp.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_mems_pkg.sv
// Shared types and sizing helpers for the ping-pong input memory.
package input_mems_pkg;

    // Load sequencer states. IDLE waits for the first beat of a stream.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2
    } load_state_e;

    // Number of A elements in an rows x k matrix.
    function automatic int unsigned a_words(input int unsigned rows, input int unsigned k);
        return rows * k;
    endfunction

    // Number of B elements in a k x cols matrix.
    function automatic int unsigned b_words(input int unsigned k, input int unsigned cols);
        return k * cols;
    endfunction

endpackage

// File: rtl/pp_bank.sv
// Single-clock RAM bank: one write port, one read port with a registered output.
module pp_bank #(
    parameter  int WIDTH     = 12,
    parameter  int DEPTH     = 56,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    // NOTE: the storage array has no reset so it maps onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, cleared while reset is held.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/input_mems_pp.sv
// Ping-pong input memory: loads A/B over AXI-Stream into one buffer set while
// the compute engine reads the other. Each set records its K and which A bank
// it reads, so a stream may reuse the previously loaded A and carry only B.
module input_mems_pp
    import input_mems_pkg::*;
#(
    parameter  int INW         = 12,
    parameter  int M           = 7,
    parameter  int N           = 9,
    parameter  int MAXK        = 8,
    localparam int K_BITS      = $clog2(MAXK + 1),
    localparam int A_ADDR_BITS = $clog2(M * MAXK),
    localparam int B_ADDR_BITS = $clog2(MAXK * N)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [INW-1:0]                AXIS_TDATA,
    input  logic                          AXIS_TVALID,
    input  logic [K_BITS:0]               AXIS_TUSER,
    output logic                          AXIS_TREADY,
    output logic                          matrices_loaded,
    input  logic                          compute_finished,
    output logic [K_BITS-1:0]             K,
    input  logic [A_ADDR_BITS-1:0]        A_read_addr,
    output logic signed [INW-1:0]         A_data,
    input  logic [B_ADDR_BITS-1:0]        B_read_addr,
    output logic signed [INW-1:0]         B_data
);

    localparam int CNT_BITS = (A_ADDR_BITS > B_ADDR_BITS) ? A_ADDR_BITS : B_ADDR_BITS;

    // Load sequencer state
    load_state_e         state;
    logic [CNT_BITS-1:0] cnt;
    logic [K_BITS-1:0]   cur_k;
    logic                cur_new_a;

    // Per-set bookkeeping and set pointers
    logic [1:0]          full;
    logic [1:0]          a_src;
    logic [K_BITS-1:0]   k_set [2];
    logic                load_set;
    logic                comp_set;
    logic                last_set;
    logic                ready_en;

    // Decoded stream / control terms
    logic [K_BITS-1:0]   tuser_k;
    logic                tuser_new_a;
    logic                k_ok;
    logic                hs;
    logic                load_done;
    logic                release_set;
    logic                alias_block;
    logic [CNT_BITS-1:0] a_last;
    logic [CNT_BITS-1:0] b_last;

    // Bank ports
    logic [1:0]          a_we;
    logic [1:0]          b_we;
    logic [INW-1:0]      a_rd [2];
    logic [INW-1:0]      b_rd [2];
    logic                a_sel_q;
    logic                b_sel_q;

    assign tuser_k     = AXIS_TUSER[K_BITS:1];
    assign tuser_new_a = AXIS_TUSER[0];
    assign k_ok        = (tuser_k != '0) && (tuser_k <= K_BITS'(MAXK));
    assign hs          = AXIS_TVALID && AXIS_TREADY;

    assign a_last = CNT_BITS'(a_words(M, 32'(cur_k)) - 1);
    assign b_last = CNT_BITS'(b_words(32'(cur_k), N) - 1);

    assign load_done   = hs && (state == LOAD_B) && (cnt == b_last);
    assign release_set = compute_finished && full[comp_set];

    // A new A must not overwrite the bank the other (full) set is still reading.
    assign alias_block = tuser_new_a && full[~load_set] && (a_src[~load_set] == load_set);

    // Ready comes only from registers plus the first-beat TUSER; never from TVALID.
    assign AXIS_TREADY = ready_en && ((state != IDLE) || (!full[load_set] && !alias_block));

    assign matrices_loaded = full[comp_set];
    assign K               = full[comp_set] ? k_set[comp_set] : '0;

    assign A_data = a_sel_q ? a_rd[1] : a_rd[0];
    assign B_data = b_sel_q ? b_rd[1] : b_rd[0];

    // Steer the accepted beat into the A or B bank of the set being loaded.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        a_we = '0;
        b_we = '0;
        if (hs) begin
            unique case (state)
                IDLE: begin
                    if (k_ok) begin
                        if (tuser_new_a) a_we[load_set] = 1'b1;
                        else             b_we[load_set] = 1'b1;
                    end
                end
                LOAD_A:  a_we[load_set] = 1'b1;
                LOAD_B:  b_we[load_set] = 1'b1;
                default: ;
            endcase
        end
    end

    // Load sequencer: latch K/new_A on the first beat, then count A and B beats.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_k     <= '0;
            cur_new_a <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Out-of-range K is consumed and dropped.
                    if (hs && k_ok) begin
                        cur_k     <= tuser_k;
                        cur_new_a <= tuser_new_a;
                        cnt       <= CNT_BITS'(1);
                        state     <= tuser_new_a ? LOAD_A : LOAD_B;
                    end
                end
                LOAD_A: begin
                    if (hs) begin
                        if (cnt == a_last) begin
                            cnt   <= '0;
                            state <= LOAD_B;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (hs) begin
                        if (cnt == b_last) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Set bookkeeping: release of the compute set and commit of a finished load.
    // The two always touch different sets, so both may happen in one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full     <= '0;
            a_src    <= '0;
            k_set[0] <= '0;
            k_set[1] <= '0;
            load_set <= 1'b0;
            comp_set <= 1'b0;
            last_set <= 1'b0;
        end else begin
            if (release_set) begin
                full[comp_set] <= 1'b0;
                comp_set       <= ~comp_set;
            end
            if (load_done) begin
                full[load_set]  <= 1'b1;
                k_set[load_set] <= cur_k;
                a_src[load_set] <= cur_new_a ? load_set : a_src[last_set];
                last_set        <= load_set;
                load_set        <= ~load_set;
            end
        end
    end

    // Read-side selects aligned with the bank read registers; ready enable after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_sel_q  <= 1'b0;
            b_sel_q  <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            a_sel_q  <= a_src[comp_set];
            b_sel_q  <= comp_set;
            ready_en <= 1'b1;
        end
    end

    // Two A banks and two B banks, all sharing the compute-side read address.
    for (genvar s = 0; s < 2; s++) begin : g_set
        pp_bank #(.WIDTH(INW), .DEPTH(M * MAXK)) u_a_bank (
            .clk     (clk),
            .reset   (reset),
            .we      (a_we[s]),
            .wr_addr (A_ADDR_BITS'(cnt)),
            .wr_data (AXIS_TDATA),
            .rd_addr (A_read_addr),
            .rd_data (a_rd[s])
        );

        pp_bank #(.WIDTH(INW), .DEPTH(MAXK * N)) u_b_bank (
            .clk     (clk),
            .reset   (reset),
            .we      (b_we[s]),
            .wr_addr (B_ADDR_BITS'(cnt)),
            .wr_data (AXIS_TDATA),
            .rd_addr (B_read_addr),
            .rd_data (b_rd[s])
        );
    end

endmodule

// File: tb/tb_input_mems_pp.sv
// Self-checking bench for input_mems_pp: directed sequence with random data,
// checked against a transaction-level model of the two buffer sets.
module tb_input_mems_pp;

    localparam int INW  = 12;
    localparam int M    = 7;
    localparam int N    = 9;
    localparam int MAXK = 8;
    localparam int KB   = $clog2(MAXK + 1);
    localparam int AB   = $clog2(M * MAXK);
    localparam int BB   = $clog2(MAXK * N);

    logic                 clk;
    logic                 reset;
    logic [INW-1:0]       AXIS_TDATA;
    logic                 AXIS_TVALID;
    logic [KB:0]          AXIS_TUSER;
    logic                 AXIS_TREADY;
    logic                 matrices_loaded;
    logic                 compute_finished;
    logic [KB-1:0]        K;
    logic [AB-1:0]        A_read_addr;
    logic signed [INW-1:0] A_data;
    logic [BB-1:0]        B_read_addr;
    logic signed [INW-1:0] B_data;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: contents of the four banks plus per-set status.
    logic [INW-1:0] mA [2][M*MAXK];
    logic [INW-1:0] mB [2][MAXK*N];
    bit             mfull [2];
    int             mk    [2];
    bit             msrc  [2];
    bit             mload, mcomp, mlast;

    // Stimulus payload for the next stream.
    logic [INW-1:0] tx_a [M*MAXK];
    logic [INW-1:0] tx_b [MAXK*N];

    input_mems_pp #(.INW(INW), .M(M), .N(N), .MAXK(MAXK)) dut (
        .clk              (clk),
        .reset            (reset),
        .AXIS_TDATA       (AXIS_TDATA),
        .AXIS_TVALID      (AXIS_TVALID),
        .AXIS_TUSER       (AXIS_TUSER),
        .AXIS_TREADY      (AXIS_TREADY),
        .matrices_loaded  (matrices_loaded),
        .compute_finished (compute_finished),
        .K                (K),
        .A_read_addr      (A_read_addr),
        .A_data           (A_data),
        .B_read_addr      (B_read_addr),
        .B_data           (B_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready(input bit new_a);
        return !mfull[mload] && !(new_a && mfull[!mload] && (msrc[!mload] == mload));
    endfunction

    function automatic void model_release();
        if (mfull[mcomp]) begin
            mfull[mcomp] = 1'b0;
            mcomp        = !mcomp;
        end
    endfunction

    task automatic check_status(input string tag);
        chk({tag, "_loaded"}, 32'(matrices_loaded), 32'(mfull[mcomp]));
        chk({tag, "_K"}, 32'(K), mfull[mcomp] ? 32'(mk[mcomp]) : 32'd0);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < M * MAXK; i++) tx_a[i] = INW'(i);
        for (int j = 0; j < MAXK * N; j++) tx_b[j] = INW'(100 + j);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < M * MAXK; i++) tx_a[i] = INW'($urandom());
        for (int j = 0; j < MAXK * N; j++) tx_b[j] = INW'($urandom());
    endtask

    task automatic do_reset();
        reset = 1'b0;
        AXIS_TVALID = 1'b0;
        compute_finished = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tready", 32'(AXIS_TREADY), 32'd0);
        chk("rst_loaded", 32'(matrices_loaded), 32'd0);
        chk("rst_K", 32'(K), 32'd0);
        chk("rst_A_data", {20'd0, A_data}, 32'd0);
        chk("rst_B_data", {20'd0, B_data}, 32'd0);
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            mfull[s] = 1'b0;
            mk[s]    = 0;
            msrc[s]  = 1'b0;
        end
        mload = 1'b0; mcomp = 1'b0; mlast = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Send a stream (or only its first `limit` beats); optionally pulse
    // compute_finished in the same cycle as the last beat.
    task automatic send_stream(input int k, input bit new_a, input int limit, input bit rel_last);
        int  total;
        int  n;
        int  na;
        bit  ok;
        total = new_a ? (M * k + k * N) : k * N;
        n     = (limit < total) ? limit : total;
        na    = new_a ? M * k : 0;
        ok    = 1'b1;
        for (int i = 0; i < n; i++) begin
            int waited = 0;
            AXIS_TVALID = 1'b1;
            AXIS_TUSER  = (i == 0) ? {KB'(k), new_a} : (KB+1)'($urandom());
            AXIS_TDATA  = (i < na) ? tx_a[i] : tx_b[i - na];
            while (!AXIS_TREADY && waited < 200) begin
                @(posedge clk);
                #1;
                waited++;
            end
            if (!AXIS_TREADY) begin
                chk("tready_timeout", 32'(AXIS_TREADY), 32'd1);
                ok = 1'b0;
                break;
            end
            if (rel_last && i == total - 1) begin
                chk("loaded_before_overlap", 32'(matrices_loaded), 32'(mfull[mcomp]));
                compute_finished = 1'b1;
            end
            @(posedge clk);
            #1;
            compute_finished = 1'b0;
        end
        AXIS_TVALID = 1'b0;
        if (ok && n == total) begin
            if (rel_last) model_release();
            for (int i = 0; i < na; i++) mA[mload][i] = tx_a[i];
            for (int j = 0; j < k * N; j++) mB[mload][j] = tx_b[j];
            mfull[mload] = 1'b1;
            mk[mload]    = k;
            msrc[mload]  = new_a ? mload : msrc[mlast];
            mlast        = mload;
            mload        = !mload;
        end
    endtask

    // A single first beat with an illegal K: accepted, then ignored.
    task automatic drop_beat(input int kval, input bit new_a);
        int waited = 0;
        AXIS_TVALID = 1'b1;
        AXIS_TUSER  = {KB'(kval), new_a};
        AXIS_TDATA  = INW'($urandom());
        while (!AXIS_TREADY && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("drop_tready", 32'(AXIS_TREADY), 32'd1);
        @(posedge clk);
        #1;
        AXIS_TVALID = 1'b0;
    endtask

    task automatic pulse_release();
        compute_finished = 1'b1;
        @(posedge clk);
        #1;
        compute_finished = 1'b0;
        model_release();
    endtask

    task automatic rd_at(input string tag, input int a, input int b);
        A_read_addr = AB'(a);
        B_read_addr = BB'(b);
        @(posedge clk);
        #1;
        chk({tag, "_A"}, {20'd0, A_data}, {20'd0, mA[msrc[mcomp]][a]});
        chk({tag, "_B"}, {20'd0, B_data}, {20'd0, mB[mcomp][b]});
    endtask

    task automatic rd_rand(input string tag, input int cnt);
        int k;
        k = mk[mcomp];
        for (int i = 0; i < cnt; i++) begin
            rd_at(tag, $urandom_range(M * k - 1, 0), $urandom_range(k * N - 1, 0));
        end
    endtask

    task automatic check_stall(input string tag, input int kval, input bit new_a, input int cycles);
        AXIS_TUSER = {KB'(kval), new_a};
        for (int c = 0; c < cycles; c++) begin
            chk(tag, 32'(AXIS_TREADY), 32'(exp_ready(new_a)));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset            = 1'b0;
        AXIS_TDATA       = '0;
        AXIS_TVALID      = 1'b0;
        AXIS_TUSER       = '0;
        compute_finished = 1'b0;
        A_read_addr      = '0;
        B_read_addr      = '0;

        // Basic load: A[i]=i, B[j]=100+j, K=4.
        do_reset();
        chk("idle_tready", 32'(AXIS_TREADY), 32'd1);
        fill_ramp();
        send_stream(4, 1'b1, 1000, 1'b0);
        check_status("basic");
        rd_at("basic_last", 27, 35);
        chk("basic_A27_const", {20'd0, A_data}, 32'd27);
        chk("basic_B35_const", {20'd0, B_data}, 32'd135);
        rd_rand("basic", 3);

        // Second set loads while the first is held; third load stalls.
        fill_rand();
        send_stream(2, 1'b1, 1000, 1'b0);
        check_status("second");
        check_stall("both_full_tready", 3, 1'b1, 4);
        pulse_release();
        check_status("after_rel1");
        chk("after_rel1_K2", 32'(K), 32'd2);
        rd_rand("set1", 3);
        fill_rand();
        send_stream(3, 1'b1, 1000, 1'b0);
        pulse_release();
        check_status("after_rel2");
        rd_rand("set0_k3", 3);
        pulse_release();
        check_status("all_released");
        pulse_release();
        check_status("ignored_release");

        // Reuse A: new_A=0 load shares A0.
        do_reset();
        fill_ramp();
        send_stream(4, 1'b1, 1000, 1'b0);
        for (int j = 0; j < MAXK * N; j++) tx_b[j] = INW'(200 + j);
        send_stream(4, 1'b0, 1000, 1'b0);
        pulse_release();
        check_status("reuse");
        rd_at("reuse", 5, 0);
        chk("reuse_A5_const", {20'd0, A_data}, 32'd5);
        chk("reuse_B0_const", {20'd0, B_data}, 32'd200);

        // Alias hold: new A into set 0 must wait while set 1 reads A0.
        check_stall("alias_tready", 1, 1'b1, 4);
        pulse_release();
        check_status("alias_rel");
        fill_rand();
        send_stream(1, 1'b1, 1000, 1'b0);
        check_status("alias_load");
        rd_rand("alias", 3);

        // Last beat coincides with compute_finished: no gap in matrices_loaded.
        fill_rand();
        send_stream(3, 1'b0, 1000, 1'b1);
        check_status("overlap");
        chk("overlap_K3", 32'(K), 32'd3);
        rd_rand("overlap", 4);

        // Illegal K on the first beat, then a normal load.
        do_reset();
        drop_beat(0, 1'b1);
        drop_beat(9, 1'b0);
        check_status("dropped");
        chk("dropped_tready", 32'(AXIS_TREADY), 32'd1);
        fill_rand();
        send_stream(2, 1'b1, 1000, 1'b0);
        check_status("after_drop");
        rd_rand("after_drop", 3);

        // Reset in the middle of the B phase, then a full K=MAXK load.
        fill_rand();
        send_stream(5, 1'b1, 35 + 10, 1'b0);
        do_reset();
        check_status("post_reset");
        fill_rand();
        send_stream(MAXK, 1'b1, 1000, 1'b0);
        check_status("maxk");
        rd_at("maxk_last", M * MAXK - 1, MAXK * N - 1);
        rd_rand("maxk", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
